exception_controller: RTL and testbench

Sequences precise exceptions, interrupts and ERET into the Coprocessor 0 register file. It sits between the memory-stage commit point and CP0 and performs four steps. It prioritises the pending causes of the committing instruction, and checks them against Status/Cause interrupt masking. It drives the one-cycle `exception` code into CP0, flushes the pipeline for a fixed number of cycles, then issues a single PC redirect to the handler vector or to EPC.

---
 rtl/exception_controller.sv | 153 +++++++++++++++
 tb/tb_exception_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// exception_controller: prioritises commit-point exceptions/interrupts/ERET, drives CP0, flushes, then redirects.
// Optional feature macro: EXC_CTRL_TIMER_INT_EN (ORs timer_interrupt into IP[7] before masking).
`default_nettype none

module exception_controller #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 16'h0380,
    parameter int                    FLUSH_CYCLES = 2,
    parameter int                    DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic                  req_illegal,
    input  logic                  req_syscall,
    input  logic                  req_trap,
    input  logic                  req_overflow,
    input  logic                  req_eret,
    input  logic                  pipe_exec_stall,
    input  logic [31:0]           status,
    input  logic [31:0]           cause,
    input  logic [ADDR_WIDTH-1:0] epc,
    input  logic                  timer_interrupt,
    output logic [DATA_WIDTH-1:0] exception,
    output logic [ADDR_WIDTH-1:0] exc_pc,
    output logic                  flush,
    output logic                  busy,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam logic [DATA_WIDTH-1:0] EXCEPT_NONE      = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_INTERRUPT = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_ILLEGAL   = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_SYSCALL   = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_TRAP      = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_OVERFLOW  = DATA_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] EXCEPT_ERET      = DATA_WIDTH'(6);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYCLES);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_count;
    logic [DATA_WIDTH-1:0] r_exception;
    logic [ADDR_WIDTH-1:0] r_exc_pc;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;

    logic [7:0]            w_ip;
    logic                  w_int_pending;
    logic                  w_any_req;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_code;
    logic                  w_flush;
    logic                  w_busy;
    logic                  w_redirect_valid;
    logic                  w_unused;

`ifdef EXC_CTRL_TIMER_INT_EN
    assign w_ip     = cause[15:8] | {timer_interrupt, 7'b0};
    assign w_unused = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};
`else
    assign w_ip     = cause[15:8];
    assign w_unused = ^{status[31:16], status[7:2], cause[31:16], cause[7:0], timer_interrupt};
`endif

    assign w_int_pending = (|(w_ip & status[15:8])) & status[0] & ~status[1];
    assign w_any_req     = req_illegal | req_syscall | req_trap | req_overflow | req_eret;
    assign w_accept      = (r_state == S_IDLE) & mem_valid & ~pipe_exec_stall
                         & (w_int_pending | w_any_req);

    always_comb begin
        w_code = EXCEPT_NONE;
        if (w_int_pending)     w_code = EXCEPT_INTERRUPT;
        else if (req_illegal)  w_code = EXCEPT_ILLEGAL;
        else if (req_syscall)  w_code = EXCEPT_SYSCALL;
        else if (req_trap)     w_code = EXCEPT_TRAP;
        else if (req_overflow) w_code = EXCEPT_OVERFLOW;
        else if (req_eret)     w_code = EXCEPT_ERET;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next_state = S_FLUSH;
            S_FLUSH:    if (r_count <= 4'd1) w_next_state = S_REDIRECT;
            S_REDIRECT: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_flush          = 1'b0;
        w_busy           = 1'b0;
        w_redirect_valid = 1'b0;
        case (r_state)
            S_FLUSH: begin
                w_flush = 1'b1;
                w_busy  = 1'b1;
            end
            S_REDIRECT: begin
                w_flush          = 1'b1;
                w_busy           = 1'b1;
                w_redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // The exception code is a one-cycle pulse; exc_pc and redirect_pc persist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exception   <= EXCEPT_NONE;
            r_exc_pc      <= '0;
            r_target      <= '0;
            r_redirect_pc <= '0;
            r_count       <= 4'd0;
        end else begin
            r_exception <= w_accept ? w_code : EXCEPT_NONE;
            if (w_accept) begin
                r_exc_pc <= mem_pc;
                r_target <= (w_code == EXCEPT_ERET) ? epc : EXC_VECTOR;
                r_count  <= c_FLUSH_INIT;
            end else if (r_state == S_FLUSH && r_count > 4'd1) begin
                r_count <= r_count - 4'd1;
            end
            if (r_state == S_FLUSH && w_next_state == S_REDIRECT) begin
                r_redirect_pc <= r_target;
            end
        end
    end

    assign exception      = r_exception;
    assign exc_pc         = r_exc_pc;
    assign flush          = w_flush;
    assign busy           = w_busy;
    assign redirect_valid = w_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_exception_controller.sv
// tb_exception_controller: directed self-checking bench for exception_controller (FLUSH_CYCLES=2).
`default_nettype none

module tb_exception_controller;

    localparam logic [31:0] E_NONE = 32'd0;
    localparam logic [31:0] E_INT  = 32'd1;
    localparam logic [31:0] E_ILL  = 32'd2;
    localparam logic [31:0] E_SYS  = 32'd3;
    localparam logic [31:0] E_TRAP = 32'd4;
    localparam logic [31:0] E_OVF  = 32'd5;
    localparam logic [31:0] E_ERET = 32'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [15:0] mem_pc;
    logic        req_illegal, req_syscall, req_trap, req_overflow, req_eret;
    logic        pipe_exec_stall;
    logic [31:0] status, cause;
    logic [15:0] epc;
    logic        timer_interrupt;
    logic [31:0] exception;
    logic [15:0] exc_pc;
    logic        flush, busy, redirect_valid;
    logic [15:0] redirect_pc;

    int tests  = 0;
    int failed = 0;

    exception_controller dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .req_illegal(req_illegal), .req_syscall(req_syscall), .req_trap(req_trap),
        .req_overflow(req_overflow), .req_eret(req_eret), .pipe_exec_stall(pipe_exec_stall),
        .status(status), .cause(cause), .epc(epc), .timer_interrupt(timer_interrupt),
        .exception(exception), .exc_pc(exc_pc), .flush(flush), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_pc = 16'h0; pipe_exec_stall = 0;
        req_illegal = 0; req_syscall = 0; req_trap = 0; req_overflow = 0; req_eret = 0;
        status = 32'h0; cause = 32'h0; timer_interrupt = 0;
    endtask

    initial begin
        idle_inputs();
        epc   = 16'h0;
        rst_n = 0;
        #12;
        chk("rst_exception", exception, E_NONE);
        chk("rst_flush", {31'b0, flush}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_redirect_valid", {31'b0, redirect_valid}, 0);
        chk("rst_redirect_pc", {16'b0, redirect_pc}, 0);
        chk("rst_exc_pc", {16'b0, exc_pc}, 0);
        rst_n = 1;
        tick();

        // Syscall at 0x0040
        mem_valid = 1; mem_pc = 16'h0040; req_syscall = 1;
        tick(); idle_inputs();
        chk("sys_code", exception, E_SYS);
        chk("sys_exc_pc", {16'b0, exc_pc}, 32'h0040);
        chk("sys_flush1", {31'b0, flush}, 1);
        chk("sys_busy1", {31'b0, busy}, 1);
        chk("sys_rv1", {31'b0, redirect_valid}, 0);
        tick();
        chk("sys_code_pulse", exception, E_NONE);
        chk("sys_flush2", {31'b0, flush}, 1);
        chk("sys_rv2", {31'b0, redirect_valid}, 0);
        tick();
        chk("sys_flush3", {31'b0, flush}, 1);
        chk("sys_rv3", {31'b0, redirect_valid}, 1);
        chk("sys_rpc", {16'b0, redirect_pc}, 32'h0380);
        tick();
        chk("sys_flush_end", {31'b0, flush}, 0);
        chk("sys_busy_end", {31'b0, busy}, 0);
        chk("sys_rv_end", {31'b0, redirect_valid}, 0);
        chk("sys_rpc_hold", {16'b0, redirect_pc}, 32'h0380);
        chk("sys_exc_pc_hold", {16'b0, exc_pc}, 32'h0040);

        // req_* without mem_valid is ignored
        req_trap = 1;
        tick(); idle_inputs();
        chk("nomv_busy", {31'b0, busy}, 0);
        chk("nomv_code", exception, E_NONE);

        // Interrupt IP2/IM2 beats overflow
        mem_valid = 1; mem_pc = 16'h0100; req_overflow = 1;
        status = 32'h0000_0401; cause = 32'h0000_0400;
        tick(); idle_inputs();
        chk("int_prio_code", exception, E_INT);
        chk("int_prio_pc", {16'b0, exc_pc}, 32'h0100);
        tick(); tick(); tick();
        chk("int_prio_idle", {31'b0, busy}, 0);

        // Same with EXL=1: overflow wins
        mem_valid = 1; mem_pc = 16'h0104; req_overflow = 1;
        status = 32'h0000_0403; cause = 32'h0000_0400;
        tick(); idle_inputs();
        chk("exl_code", exception, E_OVF);
        tick(); tick(); tick();

        // ERET to epc=0x1234, epc changes during FLUSH
        mem_valid = 1; mem_pc = 16'h0200; req_eret = 1; epc = 16'h1234;
        tick(); idle_inputs();
        chk("eret_code", exception, E_ERET);
        epc = 16'h5555;
        tick();
        tick();
        chk("eret_rv", {31'b0, redirect_valid}, 1);
        chk("eret_rpc", {16'b0, redirect_pc}, 32'h1234);
        tick();

        // Illegal held off by stall for 3 cycles
        mem_valid = 1; mem_pc = 16'h0300; req_illegal = 1; pipe_exec_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy", {31'b0, busy}, 0);
            chk("stall_code", exception, E_NONE);
        end
        pipe_exec_stall = 0;
        tick(); idle_inputs();
        chk("unstall_code", exception, E_ILL);
        chk("unstall_pc", {16'b0, exc_pc}, 32'h0300);
        tick(); tick(); tick();

        // Request during FLUSH ignored
        mem_valid = 1; mem_pc = 16'h0400; req_trap = 1;
        tick(); idle_inputs();
        chk("trap_code", exception, E_TRAP);
        mem_valid = 1; mem_pc = 16'h0404; req_illegal = 1;
        tick();
        chk("inflush_code", exception, E_NONE);
        chk("inflush_pc", {16'b0, exc_pc}, 32'h0400);
        tick(); idle_inputs();
        chk("inflush_rv", {31'b0, redirect_valid}, 1);
        tick();
        chk("inflush_idle", {31'b0, busy}, 0);
        chk("inflush_code2", exception, E_NONE);

        // Async reset during FLUSH
        mem_valid = 1; mem_pc = 16'h0500; req_syscall = 1;
        tick(); idle_inputs();
        chk("prerst_busy", {31'b0, busy}, 1);
        rst_n = 0;
        #1;
        chk("arst_code", exception, E_NONE);
        chk("arst_flush", {31'b0, flush}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_exc_pc", {16'b0, exc_pc}, 0);
        chk("arst_rpc", {16'b0, redirect_pc}, 0);
        tick();
        #2 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_rv", {31'b0, redirect_valid}, 0);
            chk("postrst_flush", {31'b0, flush}, 0);
        end

        // Timer path: IM7=1, IE=1, IP7=0
        mem_valid = 1; mem_pc = 16'h0600; status = 32'h0000_8001; timer_interrupt = 1;
        tick(); idle_inputs();
`ifdef EXC_CTRL_TIMER_INT_EN
        chk("timer_code", exception, E_INT);
        chk("timer_busy", {31'b0, busy}, 1);
`else
        chk("timer_code", exception, E_NONE);
        chk("timer_busy", {31'b0, busy}, 0);
`endif
        tick(); tick(); tick();
        chk("final_idle", {31'b0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
